// File: rtl/wait_merge_pkg.sv
// Shared types and constants for the two-channel wait/merge join controller.
package wait_merge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Counter must be able to hold the terminal value itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int TIMEOUT_CYCLES_DEF = 255;
   localparam int TO_CNT_W           = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/merge_slot.sv
// One-entry token slot: captures on drive when empty, flags overrun when full.
module merge_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         drive,
   input  logic [W-1:0] din,
   input  logic         clr,
   output logic         full,
   output logic [W-1:0] q,
   output logic         overrun
);

   always_ff @(posedge clk) begin
      if (rst) begin
         full    <= 1'b0;
         q       <= '0;
         overrun <= 1'b0;
      end else begin
         // A drive on the release cycle still sees the slot full and is dropped.
         overrun <= drive & full;
         if (clr)
            full <= 1'b0;
         else if (drive && !full) begin
            full <= 1'b1;
            q    <= din;
         end
      end
   end

endmodule

// File: rtl/sync_wait_merge_ctrl.sv
// Two-channel join: merges one token per channel into {data1, data0}.
// Define WAIT_MERGE_TIMEOUT_EN to re-issue the merged token after a WAIT timeout.
module sync_wait_merge_ctrl
   import wait_merge_pkg::*;
#(
   parameter int DATA_WIDTH_I0  = 18,
   parameter int DATA_WIDTH_I1  = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_drive0,
   input  logic [DATA_WIDTH_I0-1:0]             i_data0,
   output logic                                 o_free0,
   input  logic                                 i_drive1,
   input  logic [DATA_WIDTH_I1-1:0]             i_data1,
   output logic                                 o_free1,
   output logic                                 o_driveNext,
   output logic [DATA_WIDTH_I0+DATA_WIDTH_I1-1:0] o_data,
   input  logic                                 i_freeNext,
   output logic                                 o_busy,
   output logic                                 o_overrun,
   output logic                                 o_err_timeout
);

   state_t                     state_q, state_d;
   logic                       full0, full1, ovr0, ovr1;
   logic [DATA_WIDTH_I0-1:0]   q0;
   logic [DATA_WIDTH_I1-1:0]   q1;
   logic                       take_free;
   logic                       to_hit;
   logic                       free_q;

   merge_slot #(.W(DATA_WIDTH_I0)) u_slot0 (
      .clk(clk), .rst(rst), .drive(i_drive0), .din(i_data0), .clr(take_free),
      .full(full0), .q(q0), .overrun(ovr0)
   );

   merge_slot #(.W(DATA_WIDTH_I1)) u_slot1 (
      .clk(clk), .rst(rst), .drive(i_drive1), .din(i_data1), .clr(take_free),
      .full(full1), .q(q1), .overrun(ovr1)
   );

`ifdef WAIT_MERGE_TIMEOUT_EN
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] to_cnt;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (rst || state_q != WAIT)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (to_hit)
         err_q <= 1'b1;
   end

   assign o_err_timeout = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign o_err_timeout      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      take_free = 1'b0;
      to_hit    = 1'b0;
      unique case (state_q)
         IDLE: if (full0 && full1) state_d = SEND;
         SEND: state_d = WAIT;
         WAIT: begin
            // A release on the terminal-count cycle takes priority over a retry.
            if (i_freeNext) begin
               take_free = 1'b1;
               state_d   = IDLE;
            end
`ifdef WAIT_MERGE_TIMEOUT_EN
            else if (to_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
               to_hit  = 1'b1;
               state_d = SEND;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are registered so they line up with the SEND / release cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_driveNext <= 1'b0;
         o_data      <= '0;
         free_q      <= 1'b0;
      end else begin
         o_driveNext <= (state_d == SEND);
         free_q      <= take_free;
         if (state_d == SEND)
            o_data <= {q1, q0};
      end
   end

   assign o_free0   = free_q;
   assign o_free1   = free_q;
   assign o_overrun = ovr0 | ovr1;
   assign o_busy    = (state_q != IDLE) | full0 | full1;

endmodule

// File: tb/tb_sync_wait_merge_ctrl.sv
// Directed self-checking bench for sync_wait_merge_ctrl.
module tb_sync_wait_merge_ctrl;

   localparam int W0 = 18;
   localparam int W1 = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_drive0, i_drive1, i_freeNext;
   logic [W0-1:0]     i_data0;
   logic [W1-1:0]     i_data1;
   logic              o_free0, o_free1, o_driveNext, o_busy, o_overrun, o_err_timeout;
   logic [W0+W1-1:0]  o_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sync_wait_merge_ctrl #(
      .DATA_WIDTH_I0(W0),
      .DATA_WIDTH_I1(W1),
`ifdef WAIT_MERGE_TIMEOUT_EN
      .TIMEOUT_CYCLES(4)
`else
      .TIMEOUT_CYCLES(255)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .i_drive0(i_drive0), .i_data0(i_data0), .o_free0(o_free0),
      .i_drive1(i_drive1), .i_data1(i_data1), .o_free1(o_free1),
      .o_driveNext(o_driveNext), .o_data(o_data), .i_freeNext(i_freeNext),
      .o_busy(o_busy), .o_overrun(o_overrun), .o_err_timeout(o_err_timeout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_drive0   = 1'b0;
      i_drive1   = 1'b0;
      i_freeNext = 1'b0;
      i_data0    = '0;
      i_data1    = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         if (c == 3) rst = 1'b0;
         step();
         tests++;
         if ({o_driveNext, o_free0, o_free1, o_overrun, o_busy, o_err_timeout} !== 6'b0 || o_data !== '0) begin
            fails++;
            $display("FAIL reset c=%0d got drv=%b f0=%b f1=%b ovr=%b busy=%b err=%b data=%h, want all 0",
                     c, o_driveNext, o_free0, o_free1, o_overrun, o_busy, o_err_timeout, o_data);
         end
      end
   endtask

   task automatic test_basic();
      for (int c = 0; c <= 12; c++) begin
         tests++;
         if (o_driveNext !== (c == 7)) begin
            fails++; $display("FAIL basic_drv c=%0d got %b want %b", c, o_driveNext, c == 7);
         end
         tests++;
         if (o_free0 !== (c == 11) || o_free1 !== (c == 11)) begin
            fails++; $display("FAIL basic_free c=%0d got %b%b want %b", c, o_free0, o_free1, c == 11);
         end
         tests++;
         if (o_busy !== (c >= 3 && c <= 10)) begin
            fails++; $display("FAIL basic_busy c=%0d got %b want %b", c, o_busy, (c >= 3 && c <= 10));
         end
         tests++;
         if (o_err_timeout !== 1'b0 || o_overrun !== 1'b0) begin
            fails++; $display("FAIL basic_flags c=%0d got err=%b ovr=%b want 0", c, o_err_timeout, o_overrun);
         end
         if (c == 7) begin
            tests++;
            if (o_data !== {32'hDEADBEEF, 18'h2A5A5}) begin
               fails++; $display("FAIL basic_data got %h want %h", o_data, {32'hDEADBEEF, 18'h2A5A5});
            end
         end
         i_drive0   = (c == 2);
         i_data0    = (c == 2) ? 18'h2A5A5 : '0;
         i_drive1   = (c == 5);
         i_data1    = (c == 5) ? 32'hDEADBEEF : '0;
         i_freeNext = (c == 10);
         step();
      end
      idle_inputs();
   endtask

   task automatic test_simultaneous();
      for (int c = 0; c <= 10; c++) begin
         tests++;
         if (o_driveNext !== (c == 5)) begin
            fails++; $display("FAIL simul_drv c=%0d got %b want %b", c, o_driveNext, c == 5);
         end
         tests++;
         if (o_free0 !== (c == 9) || o_free1 !== (c == 9)) begin
            fails++; $display("FAIL simul_free c=%0d got %b%b want %b", c, o_free0, o_free1, c == 9);
         end
         tests++;
         if (o_busy !== (c >= 4 && c <= 8)) begin
            fails++; $display("FAIL simul_busy c=%0d got %b want %b", c, o_busy, (c >= 4 && c <= 8));
         end
         if (c == 5) begin
            tests++;
            if (o_data !== {32'hCAFEF00D, 18'h3FFFF}) begin
               fails++; $display("FAIL simul_data got %h want %h", o_data, {32'hCAFEF00D, 18'h3FFFF});
            end
         end
         i_drive0   = (c == 3);
         i_data0    = (c == 3) ? 18'h3FFFF : '0;
         i_drive1   = (c == 3);
         i_data1    = (c == 3) ? 32'hCAFEF00D : '0;
         // Release during SEND must be ignored; only the c==8 one counts.
         i_freeNext = (c == 5) || (c == 8);
         step();
      end
      idle_inputs();
   endtask

   task automatic test_overrun();
      for (int c = 0; c <= 11; c++) begin
         tests++;
         if (o_overrun !== (c == 3 || c == 8)) begin
            fails++; $display("FAIL ovr_pulse c=%0d got %b want %b", c, o_overrun, (c == 3 || c == 8));
         end
         tests++;
         if (o_driveNext !== (c == 6)) begin
            fails++; $display("FAIL ovr_drv c=%0d got %b want %b", c, o_driveNext, c == 6);
         end
         tests++;
         if (o_free0 !== (c == 10)) begin
            fails++; $display("FAIL ovr_free c=%0d got %b want %b", c, o_free0, c == 10);
         end
         if (c == 6 || c == 11) begin
            tests++;
            if (o_data !== {32'h22222222, 18'h11111}) begin
               fails++; $display("FAIL ovr_data c=%0d got %h want %h", c, o_data, {32'h22222222, 18'h11111});
            end
         end
         i_drive0   = (c == 0) || (c == 2) || (c == 7);
         i_data0    = (c == 0) ? 18'h11111 : (c == 2) ? 18'h1 : 18'h3;
         i_drive1   = (c == 4);
         i_data1    = (c == 4) ? 32'h22222222 : '0;
         i_freeNext = (c == 9);
         step();
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c <= 12; c++) begin
         tests++;
         if (o_driveNext !== (c == 3 || c == 8)) begin
            fails++; $display("FAIL b2b_drv c=%0d got %b want %b", c, o_driveNext, (c == 3 || c == 8));
         end
         tests++;
         if (o_free1 !== (c == 6 || c == 11)) begin
            fails++; $display("FAIL b2b_free c=%0d got %b want %b", c, o_free1, (c == 6 || c == 11));
         end
         tests++;
         if (o_overrun !== (c == 6)) begin
            fails++; $display("FAIL b2b_ovr c=%0d got %b want %b", c, o_overrun, c == 6);
         end
         if (c == 3) begin
            tests++;
            if (o_data !== {32'h0BBBBBBB, 18'h0AAAA}) begin
               fails++; $display("FAIL b2b_data1 got %h want %h", o_data, {32'h0BBBBBBB, 18'h0AAAA});
            end
         end
         if (c == 8 || c == 12) begin
            tests++;
            if (o_data !== {32'h87654321, 18'h12345}) begin
               fails++; $display("FAIL b2b_data2 c=%0d got %h want %h", c, o_data, {32'h87654321, 18'h12345});
            end
         end
         // c==5 drive collides with the accepted release and is dropped.
         i_drive0   = (c == 1) || (c == 5) || (c == 6);
         i_data0    = (c == 1) ? 18'h0AAAA : (c == 5) ? 18'h3FFFF : 18'h12345;
         i_drive1   = (c == 1) || (c == 6);
         i_data1    = (c == 1) ? 32'h0BBBBBBB : 32'h87654321;
         i_freeNext = (c == 5) || (c == 10);
         step();
      end
      idle_inputs();
   endtask

   task automatic test_mid_reset();
      for (int c = 0; c <= 10; c++) begin
         tests++;
         if (o_driveNext !== (c == 6)) begin
            fails++; $display("FAIL midrst_drv c=%0d got %b want %b", c, o_driveNext, c == 6);
         end
         tests++;
         if (o_busy !== (c == 1 || (c >= 3 && c <= 8))) begin
            fails++; $display("FAIL midrst_busy c=%0d got %b want %b", c, o_busy, (c == 1 || (c >= 3 && c <= 8)));
         end
         tests++;
         if (o_free0 !== (c == 9)) begin
            fails++; $display("FAIL midrst_free c=%0d got %b want %b", c, o_free0, c == 9);
         end
         if (c == 6) begin
            tests++;
            if (o_data !== {32'h7, 18'h4}) begin
               fails++; $display("FAIL midrst_data got %h want %h", o_data, {32'h7, 18'h4});
            end
         end
         rst        = (c == 1);
         i_drive0   = (c == 0) || (c == 4);
         i_data0    = (c == 0) ? 18'h5 : 18'h4;
         i_drive1   = (c == 2);
         i_data1    = 32'h7;
         i_freeNext = (c == 8);
         step();
      end
      rst = 1'b0;
      idle_inputs();
   endtask

`ifdef WAIT_MERGE_TIMEOUT_EN
   task automatic test_timeout();
      for (int c = 0; c <= 18; c++) begin
         tests++;
         if (o_driveNext !== (c == 2 || c == 8 || c == 14)) begin
            fails++; $display("FAIL to_drv c=%0d got %b want %b", c, o_driveNext, (c == 2 || c == 8 || c == 14));
         end
         tests++;
         if (o_err_timeout !== (c >= 8)) begin
            fails++; $display("FAIL to_err c=%0d got %b want %b", c, o_err_timeout, c >= 8);
         end
         tests++;
         if (o_free0 !== (c == 17)) begin
            fails++; $display("FAIL to_free c=%0d got %b want %b", c, o_free0, c == 17);
         end
         if (c == 14) begin
            tests++;
            if (o_data !== {32'h13572468, 18'h2468A}) begin
               fails++; $display("FAIL to_data got %h want %h", o_data, {32'h13572468, 18'h2468A});
            end
         end
         i_drive0   = (c == 0);
         i_data0    = 18'h2468A;
         i_drive1   = (c == 0);
         i_data1    = 32'h13572468;
         i_freeNext = (c == 16);
         step();
      end
      idle_inputs();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_simultaneous();
      test_overrun();
      test_back_to_back();
      test_mid_reset();
`ifdef WAIT_MERGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
